// File: rtl/tdc_delay_pkg.sv
// tdc_delay_pkg: shared delay-word width and FSM encodings for the TDC delay path
package tdc_delay_pkg;
  localparam int DEF_DELAY_W = 15;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PULSE = 2'd2
  } state_t;
endpackage

// File: rtl/delay_pulse_gen_if.sv
// delay_pulse_gen_if: delay load, trigger and pulse-status bundle of one delay channel
interface delay_pulse_gen_if #(
  parameter int DELAY_W = 15,
  parameter int OVR_W   = 8
);
  logic [DELAY_W-1:0] delay_in;
  logic               delay_load;
  logic               enable;
  logic               trig_in;
  logic               pulse_out;
  logic               busy;
  logic [DELAY_W-1:0] delay_active;
  logic [OVR_W-1:0]   overrun_cnt;
  modport master (
    output delay_in, delay_load, enable, trig_in,
    input  pulse_out, busy, delay_active, overrun_cnt
  );
  modport slave (
    input  delay_in, delay_load, enable, trig_in,
    output pulse_out, busy, delay_active, overrun_cnt
  );
endinterface

// File: rtl/sync_rise_detect.sv
// sync_rise_detect: synchronizes an async input and flags its rising edge for one cycle
module sync_rise_detect #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise
);
  logic [SYNC_STG-1:0] sync_q;
  logic                last_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], din};
      last_q <= sync_q[SYNC_STG-1];
    end
  assign rise = sync_q[SYNC_STG-1] & ~last_q;
endmodule

// File: rtl/delay_pulse_gen.sv
// delay_pulse_gen: emits a PULSE_W-cycle pulse a programmable number of cycles after each trigger
module delay_pulse_gen
  import tdc_delay_pkg::*;
#(
  parameter int DELAY_W  = DEF_DELAY_W,
  parameter int PULSE_W  = 8,
  parameter int SYNC_STG = 2,
  parameter int OVR_W    = 8
) (
  input logic          clk,
  input logic          resetn,
  delay_pulse_gen_if.slave bus
);
  localparam int WCNT_W = $clog2(PULSE_W + 1);
  logic               trig_evt;
  state_t             state_q, state_d;
  logic [DELAY_W-1:0] shadow_q, active_q, cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               pulse_q;
  logic [OVR_W-1:0]   ovr_q;
  sync_rise_detect #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (bus.trig_in),
    .rise   (trig_evt)
  );
  // The run latches the shadow directly, so a load in the trigger cycle lands after the run starts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    if (!bus.enable) state_d = IDLE;
    else
      case (state_q)
        IDLE:
          if (trig_evt) begin
            state_d = COUNT;
            cnt_d   = shadow_q;
          end
        COUNT:
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else begin
            state_d = PULSE;
            wcnt_d  = WCNT_W'(PULSE_W - 1);
          end
        PULSE:
          if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
          else state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      pulse_q <= state_d == PULSE;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      shadow_q <= '0;
      active_q <= '0;
      ovr_q    <= '0;
    end else begin
      if (bus.delay_load) shadow_q <= bus.delay_in;
      if (state_q == IDLE) active_q <= shadow_q;
      if (trig_evt && bus.enable && state_q != IDLE && !(&ovr_q)) ovr_q <= ovr_q + 1'b1;
    end
  assign bus.pulse_out    = pulse_q;
  assign bus.busy         = state_q != IDLE;
  assign bus.delay_active = active_q;
  assign bus.overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_delay_pulse_gen.sv
// tb_delay_pulse_gen: directed self-checking bench for delay_pulse_gen
module tb_delay_pulse_gen;
  localparam int PW = 8;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;
  delay_pulse_gen_if #(.DELAY_W(15), .OVR_W(8)) bus ();
  delay_pulse_gen #(.DELAY_W(15), .PULSE_W(PW), .SYNC_STG(2), .OVR_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic load(input int v);
    bus.delay_in   = 15'(v);
    bus.delay_load = 1'b1;
    tick();
    bus.delay_load = 1'b0;
    tick();
    chk("load_active", bus.delay_active, v);
  endtask
  task automatic toggle();
    bus.trig_in = 1'b1;
    repeat (3) tick();
    bus.trig_in = 1'b0;
    repeat (3) tick();
  endtask
  // Trigger driven just after edge E0; pulse rises d+4 ticks later (T = E0+2)
  task automatic run_check(input string tag, input int d, input int ld_at, input int ld_val);
    int n = 0;
    int rise = -1;
    int w = 0;
    bus.trig_in = 1'b1;
    while (n < d + PW + 8) begin
      if (n == ld_at) begin
        bus.delay_in   = 15'(ld_val);
        bus.delay_load = 1'b1;
      end
      tick();
      n++;
      bus.delay_load = 1'b0;
      if (n == 2) chk({tag, "_busy_pre"}, bus.busy, 0);
      if (n == 3) begin
        chk({tag, "_busy_start"}, bus.busy, 1);
        bus.trig_in = 1'b0;
      end
      if (n == 5) chk({tag, "_active_run"}, bus.delay_active, d);
      if (bus.pulse_out) begin
        if (rise < 0) rise = n;
        w++;
      end
    end
    chk({tag, "_rise"}, rise, d + 4);
    chk({tag, "_width"}, w, PW);
    chk({tag, "_busy_end"}, bus.busy, 0);
    chk({tag, "_active_after"}, bus.delay_active, ld_at >= 0 ? ld_val : d);
  endtask
  initial begin
    int k;
    logic seen;
    bus.delay_in   = '0;
    bus.delay_load = 1'b0;
    bus.enable     = 1'b1;
    bus.trig_in    = 1'b0;
    repeat (4) begin
      bus.trig_in = ~bus.trig_in;
      tick();
    end
    chk("rst_pulse", bus.pulse_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_active", bus.delay_active, 0);
    chk("rst_ovr", bus.overrun_cnt, 0);
    bus.trig_in = 1'b0;
    repeat (3) tick();
    @(negedge clk) resetn = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | bus.pulse_out | bus.busy;
    end
    chk("idle_no_pulse", seen, 0);
    load(10);
    run_check("d10", 10, -1, 0);
    load(0);
    run_check("d0", 0, -1, 0);
    load(32767);
    run_check("dmax", 32767, -1, 0);
    load(5);
    run_check("d5_ld20", 5, 4, 20);
    run_check("d20", 20, -1, 0);
    run_check("same_cycle_ld", 20, 2, 7);
    load(100);
    toggle();
    chk("ovr_busy", bus.busy, 1);
    repeat (3) toggle();
    chk("ovr3", bus.overrun_cnt, 3);
    k = 0;
    while (bus.busy && k < 200) begin
      tick();
      k++;
    end
    chk("ovr3_done", bus.busy, 0);
    bus.enable = 1'b0;
    toggle();
    chk("dis_trig_busy", bus.busy, 0);
    chk("dis_trig_ovr", bus.overrun_cnt, 3);
    bus.enable = 1'b1;
    load(50);
    bus.trig_in = 1'b1;
    repeat (3) tick();
    bus.trig_in = 1'b0;
    chk("drop_busy_run", bus.busy, 1);
    repeat (5) tick();
    bus.enable = 1'b0;
    tick();
    chk("drop_busy", bus.busy, 0);
    chk("drop_pulse", bus.pulse_out, 0);
    bus.enable = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      tick();
      seen = seen | bus.pulse_out;
    end
    chk("drop_no_pulse", seen, 0);
    chk("drop_ovr", bus.overrun_cnt, 3);
    chk("drop_shadow", bus.delay_active, 50);
    load(2000);
    toggle();
    repeat (300) toggle();
    chk("ovr_sat", bus.overrun_cnt, 255);
    k = 0;
    while (bus.busy && k < 500) begin
      tick();
      k++;
    end
    chk("ovr_sat_done", bus.busy, 0);
    load(3);
    bus.trig_in = 1'b1;
    k = 0;
    while (!bus.pulse_out && k < 20) begin
      tick();
      k++;
    end
    bus.trig_in = 1'b0;
    chk("rstmid_pulse_seen", bus.pulse_out, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_pulse", bus.pulse_out, 0);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_active", bus.delay_active, 0);
    chk("rstmid_ovr", bus.overrun_cnt, 0);
    @(negedge clk) resetn = 1'b1;
    tick();
    chk("rstmid_after", bus.pulse_out, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
